// File: rtl/_lcm_stage_if.sv
// ---------------------------------------------------------------------------
// _lcm_stage_if
//   Operand / result bundle between the GCD engine, the LCM stage and the
//   result sink.
//   Signals:
//     _num0, _num1   operand pair (WIDTH)
//     _greatest      GCD of the pair from the GCD engine (WIDTH)
//     _gcd_valid     strobe: operands and GCD are valid this cycle
//     _busy          LCM stage is working on a job
//     _done          one-cycle completion pulse
//     _lcm           2*WIDTH-bit result, held until the next completion
//     _div_zero      completion was for a zero GCD
//     _bad_gcd       (LCM_REM_CHECK_EN only) GCD did not divide _num0
//   Modports:
//     master  drives operands/strobe, observes results
//     slave   the LCM stage itself
//   Optional feature macro: LCM_REM_CHECK_EN
// ---------------------------------------------------------------------------
interface _lcm_stage_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   _num0;
  logic [WIDTH-1:0]   _num1;
  logic [WIDTH-1:0]   _greatest;
  logic               _gcd_valid;
  logic               _busy;
  logic               _done;
  logic [2*WIDTH-1:0] _lcm;
  logic               _div_zero;
`ifdef LCM_REM_CHECK_EN
  logic               _bad_gcd;
`endif

  modport master (
`ifdef LCM_REM_CHECK_EN
    input  _bad_gcd,
`endif
    output _num0, _num1, _greatest, _gcd_valid,
    input  _busy, _done, _lcm, _div_zero
  );

  modport slave (
`ifdef LCM_REM_CHECK_EN
    output _bad_gcd,
`endif
    input  _num0, _num1, _greatest, _gcd_valid,
    output _busy, _done, _lcm, _div_zero
  );
endinterface

// File: rtl/_lcm_stage.sv
// ---------------------------------------------------------------------------
// _lcm_stage
//   Consumer of the GCD engine. On _gcd_valid (sampled only while idle) it
//   captures num0/num1/gcd and computes LCM = floor(num0 / gcd) * num1 with a
//   bit-serial restoring divide (WIDTH edges) followed by a bit-serial
//   shift-add multiply. The result is presented with a one-cycle _done pulse.
//   Ports:
//     _clock   clock, all state changes on the rising edge
//     _reset   synchronous active-high reset, aborts any job in flight
//     bus      _lcm_stage_if.slave (operands in, results out)
//   Optional feature macro: LCM_REM_CHECK_EN
//     When defined, _bad_gcd reports a non-zero final division remainder
//     alongside _done. Cycle timing is the same in both builds.
//   Timing: capture edge E0, _done high in the cycle after E(2*WIDTH+1),
//   back in IDLE after E(2*WIDTH+2). A zero GCD completes after E1.
// ---------------------------------------------------------------------------
module _lcm_stage #(
  parameter int WIDTH = 8
) (
  input  logic         _clock,
  input  logic         _reset,
  _lcm_stage_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MUL_FINAL = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;       // dividend, shifted out MSB first
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   g_q, g_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;   // quotient, consumed MSB first by MUL
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] lcm_q, lcm_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
`ifdef LCM_REM_CHECK_EN
  logic               bad_q, bad_d;
`endif

  logic [WIDTH:0]     rem_ext;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    acc_d   = acc_q;
    lcm_d   = lcm_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dz_d    = dz_q;
`ifdef LCM_REM_CHECK_EN
    bad_d   = bad_q;
`endif

    // When rem_ext >= g the difference is below g, so WIDTH bits hold it.
    rem_ext = {rem_q, a_q[WIDTH-1]};
    rem_ge  = (rem_ext >= {1'b0, g_q});
    rem_sub = rem_ext[WIDTH-1:0] - g_q;

    case (state_q)
      S_IDLE: begin
        if (bus._gcd_valid) begin
          a_d     = bus._num0;
          b_d     = bus._num1;
          g_d     = bus._greatest;
          rem_d   = '0;
          quo_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        if (g_q == '0) begin
          // Zero divisor is rejected on the first DIV edge, which keeps
          // its completion one edge after capture like the normal path.
          lcm_d   = '0;
          dz_d    = 1'b1;
          done_d  = 1'b1;
`ifdef LCM_REM_CHECK_EN
          bad_d   = 1'b0;
`endif
          state_d = S_DONE;
        end else begin
          rem_d = rem_ge ? rem_sub : rem_ext[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], rem_ge};
          a_d   = a_q << 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        if (cnt_q == MUL_FINAL) begin
          // Extra edge after the last partial product moves the
          // accumulator into the held output register.
          lcm_d   = acc_q;
          done_d  = 1'b1;
`ifdef LCM_REM_CHECK_EN
          bad_d   = (rem_q != '0);
`endif
          state_d = S_DONE;
        end else begin
          acc_d = (acc_q << 1) + (quo_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : '0);
          quo_d = quo_q << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        dz_d    = 1'b0;
`ifdef LCM_REM_CHECK_EN
        bad_d   = 1'b0;
`endif
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dz_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      acc_q   <= '0;
      lcm_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef LCM_REM_CHECK_EN
      bad_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      acc_q   <= acc_d;
      lcm_q   <= lcm_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef LCM_REM_CHECK_EN
      bad_q   <= bad_d;
`endif
    end
  end

  assign bus._busy     = busy_q;
  assign bus._done     = done_q;
  assign bus._lcm      = lcm_q;
  assign bus._div_zero = dz_q;
`ifdef LCM_REM_CHECK_EN
  assign bus._bad_gcd  = bad_q;
`endif

endmodule
